// File: rtl/mem_stage_ctrl.sv
// MEM-stage memory access controller: issues one registered request per load/store,
// stalls the front of the pipe until the access completes, aborts on misalignment or timeout.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  MEM,
  input  logic [31:0] ALUVal,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        align_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t     state, state_nx;
  logic [4:0] wait_cnt;
  logic       access, aligned, tmo_hit;

  assign access  = MEM[1] | MEM[0];
  assign aligned = (ALUVal[1:0] == 2'b00);
  assign tmo_hit = (wait_cnt == 5'(TIMEOUT - 1));

  always_comb begin
    state_nx = IDLE;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall    = 1'b1;
          state_nx = aligned ? ACCESS : DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        state_nx = (mem_ack || tmo_hit) ? DONE : ACCESS;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath: request latch, wait counter, load capture and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= MEM[0];
            mem_addr  <= {ALUVal[31:2], 2'b00};
            mem_wdata <= wdata;
            wait_cnt  <= '0;
          end else if (access) begin
            align_err <= 1'b1;
            if (!MEM[0]) begin
              rdata_valid <= 1'b1;
              rdata_out   <= '0;
            end
          end
        end
        ACCESS: begin
          // A completing ack takes priority over an expiring counter.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata_valid <= 1'b1;
              rdata_out   <= mem_rdata;
            end
          end else if (tmo_hit) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            if (!mem_we) begin
              rdata_valid <= 1'b1;
              rdata_out   <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        DONE: ;
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, a random instruction stream scored
// against an arithmetic latency/error model, and reset / non-memory corner sequences.
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  MEM;
  logic [31:0] ALUVal, wdata, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, rdata_valid, align_err, timeout_err;
  logic [31:0] mem_addr, mem_wdata, rdata_out;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .MEM(MEM), .ALUVal(ALUVal), .wdata(wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .align_err(align_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mem;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_at;
    int          e_stall;
    int          e_req;
    int          e_rv;
    logic [31:0] e_rdata;
    logic        e_aerr;
    logic        e_terr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; MEM = 2'b00; ALUVal = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one instruction until the pipe accepts it (a cycle with stall low), acting
  // as the memory: ack on the ack_at-th request cycle, optional spurious acks otherwise.
  task automatic run_instr(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_at, input bit noisy,
                           output int st, output int rq, output int rv,
                           output logic [31:0] rdo, output logic hold_ok);
    int  n;
    bit  done;
    n = 0; done = 0; st = 0; rq = 0; rv = 0; rdo = '0; hold_ok = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      MEM = m; ALUVal = a; wdata = wd;
      if (mem_req) mem_ack = (rq + 1 == ack_at);
      else         mem_ack = noisy && ($urandom_range(0, 3) == 0);
      mem_rdata = mem_ack ? rd : $urandom;
      #1;
      if (stall) st++;
      if (mem_req) begin
        rq++;
        if (mem_addr !== {a[31:2], 2'b00} || mem_we !== m[0] || mem_wdata !== wd) hold_ok = 1'b0;
      end
      if (rdata_valid) begin
        rv++;
        rdo = rdata_out;
      end
      if (!stall) done = 1;
      n++;
    end
    if (!done) chk("budget", 32'd0, 32'd1);
  endtask

  logic [1:0]  m;
  logic [31:0] a, wd, rd, rdo, e_rd;
  logic        hold_ok, m_aerr, m_terr, is_acc, al, got;
  int          st, rq, rv, ack_at, r, e_req, e_st, e_rv;

  initial begin
    tbl[0] = '{2'b10, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 4,  5,  4,  1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_0000, 1,  2,  1,  0, 32'h0,         1'b0, 1'b0};
    tbl[2] = '{2'b10, 32'h0000_0022, 32'h0,         32'h1111_1111, 1,  1,  0,  1, 32'h0,         1'b1, 1'b0};
    tbl[3] = '{2'b10, 32'h0000_0040, 32'h0,         32'h2222_2222, 99, 16, 15, 1, 32'h0,         1'b0, 1'b1};
    tbl[4] = '{2'b10, 32'h0000_0044, 32'h0,         32'hCAFE_0001, 15, 16, 15, 1, 32'hCAFE_0001, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 32'h0000_07FC, 32'hA5A5_A5A5, 32'h0,         2,  3,  2,  0, 32'h0,         1'b0, 1'b0};
    tbl[6] = '{2'b01, 32'h0000_0013, 32'h0000_0009, 32'h0,         1,  1,  0,  0, 32'h0,         1'b1, 1'b0};
    tbl[7] = '{2'b00, 32'h0000_0003, 32'h0,         32'h0,         1,  0,  0,  0, 32'h0,         1'b0, 1'b0};
    tbl[8] = '{2'b10, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_F00D, 16, 16, 15, 1, 32'h0,         1'b0, 1'b1};

    // Reset values while held in reset.
    rst_n = 1'b0; MEM = 2'b00; ALUVal = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_req", mem_req, 0);       chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);     chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata_out, 0);   chk("rst_rv", rdata_valid, 0);
    chk("rst_aerr", align_err, 0);    chk("rst_terr", timeout_err, 0);
    chk("rst_stall", stall, 0);
    do_reset();

    foreach (tbl[i]) begin
      do_reset();
      run_instr(tbl[i].mem, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].ack_at, 1'b1,
                st, rq, rv, rdo, hold_ok);
      chk($sformatf("v%0d_stall", i), st, tbl[i].e_stall);
      chk($sformatf("v%0d_req", i), rq, tbl[i].e_req);
      chk($sformatf("v%0d_rv", i), rv, tbl[i].e_rv);
      if (tbl[i].e_rv != 0) chk($sformatf("v%0d_rdata", i), rdo, tbl[i].e_rdata);
      if (tbl[i].e_req != 0) chk($sformatf("v%0d_hold", i), hold_ok, 1);
      chk($sformatf("v%0d_aerr", i), align_err, tbl[i].e_aerr);
      chk($sformatf("v%0d_terr", i), timeout_err, tbl[i].e_terr);
    end

    // Non-memory stream never stalls or requests, even with stray acks.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      MEM = 2'b00; ALUVal = $urandom; mem_ack = (i % 3 == 0); mem_rdata = $urandom;
      #1;
      chk($sformatf("nop%0d_stall", i), stall, 0);
      chk($sformatf("nop%0d_req", i), mem_req, 0);
    end

    // Reset in the middle of a long wait.
    do_reset();
    @(negedge clk);
    MEM = 2'b10; ALUVal = 32'h80; wdata = 32'h55; mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_req_pre", mem_req, 1);
    chk("mid_stall_pre", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_req", mem_req, 0);       chk("mid_addr", mem_addr, 0);
    chk("mid_we", mem_we, 0);         chk("mid_wdata", mem_wdata, 0);
    chk("mid_rv", rdata_valid, 0);    chk("mid_rdata", rdata_out, 0);
    chk("mid_aerr", align_err, 0);    chk("mid_terr", timeout_err, 0);
    chk("mid_stall", stall, 1);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    repeat (2) @(negedge clk);
    MEM = 2'b00; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      mem_ack = (i < 2);
      #1;
      chk($sformatf("post%0d_req", i), mem_req, 0);
      chk($sformatf("post%0d_stall", i), stall, 0);
      chk($sformatf("post%0d_rv", i), rdata_valid, 0);
    end

    // Random instruction stream against the latency/error model.
    do_reset();
    m_aerr = 1'b0; m_terr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      m  = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom; rd = $urandom;
      r  = int'($urandom_range(0, 9));
      ack_at = (r < 6) ? r + 1 : (r < 8) ? int'($urandom_range(13, 16)) : 99;
      run_instr(m, a, wd, rd, ack_at, 1'b1, st, rq, rv, rdo, hold_ok);
      is_acc = (m != 2'b00);
      al     = (a[1:0] == 2'b00);
      got    = (ack_at <= TIMEOUT);
      e_req  = (is_acc && al) ? (got ? ack_at : TIMEOUT) : 0;
      e_st   = !is_acc ? 0 : (al ? 1 + e_req : 1);
      e_rv   = (is_acc && !m[0]) ? 1 : 0;
      e_rd   = (al && got) ? rd : 32'h0;
      if (is_acc && !al) m_aerr = 1'b1;
      if (is_acc && al && !got) m_terr = 1'b1;
      chk($sformatf("r%0d_stall", i), st, e_st);
      chk($sformatf("r%0d_req", i), rq, e_req);
      chk($sformatf("r%0d_rv", i), rv, e_rv);
      if (e_rv != 0) chk($sformatf("r%0d_rdata", i), rdo, e_rd);
      if (e_req != 0) chk($sformatf("r%0d_hold", i), hold_ok, 1);
      chk($sformatf("r%0d_aerr", i), align_err, m_aerr);
      chk($sformatf("r%0d_terr", i), timeout_err, m_terr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles in ACCESS waiting for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 MEM  input  2  MEM-stage control from EX/MEM register; bit1 MemRead, bit0 MemWrite.
REQ-005 ALUVal  input  32  byte address from EX/MEM register.
REQ-006 wdata  input  32  store data from EX/MEM register.
REQ-007 mem_ack  input  1  data memory completion, one-cycle pulse.
REQ-008 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-009 mem_req  output  1  memory request, registered.
REQ-010 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-011 mem_addr  output  32  word-aligned address, registered.
REQ-012 mem_wdata  output  32  store data, registered.
REQ-013 stall  output  1  combinational; 1 freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-014 rdata_out  output  32  load result to MEM/WB.
REQ-015 rdata_valid  output  1  one-cycle pulse, rdata_out valid.
REQ-016 align_err  output  1  sticky; misaligned access seen.
REQ-017 timeout_err  output  1  sticky; TIMEOUT expired.

Function
REQ-018 States IDLE, ACCESS, DONE; state register 2 bits; unused encoding returns to IDLE next cycle.
REQ-019 access = MEM[1] | MEM[0]; MEM=2'b11 is a write (mem_we=1).
REQ-020 IDLE: access=1 and ALUVal[1:0]==0 -> ACCESS next edge, latching mem_addr={ALUVal[31:2],2'b00}, mem_wdata=wdata, mem_we=MEM[0]; mem_req=1 from the first ACCESS cycle.
REQ-021 IDLE: access=1 and ALUVal[1:0]!=0 -> DONE next edge, no request issued, align_err set.
REQ-022 IDLE: access=0 -> remain IDLE, mem_req=0, stall=0.
REQ-023 stall = 1 when (state==IDLE and access=1) or state==ACCESS; 0 in DONE.
REQ-024 ACCESS: mem_ack=1 -> DONE next edge, mem_req=0 from that edge; read: rdata_out=mem_rdata captured on the same edge.
REQ-025 ACCESS: 5-bit wait counter cleared on entry, incremented each ACCESS cycle without ack; counter==TIMEOUT-1 with no ack -> DONE, timeout_err set, rdata_out=0.
REQ-026 mem_ack and timeout in same cycle: ack wins, timeout_err not set.
REQ-027 DONE: rdata_valid=1 for exactly this cycle if the access was a read (incl. timeout/misaligned read, rdata_out=0); 0 for writes.
REQ-028 DONE -> IDLE unconditionally next edge; stall=0 in DONE lets EX/MEM advance exactly one instruction.
REQ-029 mem_ack while in IDLE or DONE is ignored; no state change.
REQ-030 Back-to-back accesses: minimum 3 cycles per access (IDLE/ACCESS/DONE) with 1-cycle ack.
REQ-031 Stall-free latency: a non-memory instruction in IDLE causes zero stall cycles.

Reset
REQ-032 rst_n=0 asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, rdata_valid=0, align_err=0, timeout_err=0, counter=0.
REQ-033 Reset during ACCESS drops mem_req immediately; no ack afterward is consumed; stall follows REQ-023 from IDLE.
REQ-034 Sticky errors clear only by reset.

Verification
REQ-035 Load: MEM=2'b10, ALUVal=0x00000104, ack 3 cycles after mem_req with rdata=0xDEADBEEF -> mem_addr=0x104, mem_we=0, stall high 5 cycles, rdata_out=0xDEADBEEF with rdata_valid one cycle.
REQ-036 Store: MEM=2'b01, ALUVal=0x20, wdata=0x12345678, ack 1 cycle -> mem_we=1, mem_wdata=0x12345678, rdata_valid stays 0, stall 2 cycles.
REQ-037 Misaligned: MEM=2'b10, ALUVal=0x22 -> mem_req never asserted, align_err=1, rdata_valid pulse with rdata_out=0, stall 1 cycle.
REQ-038 Timeout: MEM=2'b10, no ack -> mem_req high 15 cycles, timeout_err=1, DONE then IDLE; ack on 15th cycle instead -> timeout_err stays 0.
REQ-039 Reset mid-ACCESS: rst_n low 2 cycles during wait -> mem_req=0 at once, all outputs at reset values, late ack ignored.
REQ-040 Non-memory stream: MEM=2'b00 for 10 cycles -> stall=0, mem_req=0 throughout.
